// File: rtl/mem_pkg.sv
// mem_pkg: definitions shared by mem_access_unit, the 6502 core glue and benches.
//   DEF_ADDR_WIDTH / DEF_DATA_WIDTH : default BRAM address / byte widths
//   mau_state_t                     : access sequencer states
//   mem_req_t                       : request bundle (write, word, addr, wdata)
//   cap_tok_t                       : read-capture token carried down the latency pipe
//   VEC_NMI / VEC_RESET / VEC_IRQ   : 6502 vector addresses
package mem_pkg;

  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LO    = 2'd1,
    HI    = 2'd2,
    DRAIN = 2'd3
  } mau_state_t;

  typedef struct packed {
    logic                          write;
    logic                          word;
    logic [DEF_ADDR_WIDTH-1:0]     addr;
    logic [2*DEF_DATA_WIDTH-1:0]   wdata;
  } mem_req_t;

  // One token per BRAM read cycle; it pops out of the pipe on the edge
  // where douta holds that cycle's byte.
  typedef struct packed {
    logic vld;   // a read byte is due on this edge
    logic hi;    // byte is the high half of a word
    logic last;  // final byte of the request -> respond
  } cap_tok_t;

  localparam logic [15:0] VEC_NMI   = 16'hFFFA;
  localparam logic [15:0] VEC_RESET = 16'hFFFC;
  localparam logic [15:0] VEC_IRQ   = 16'hFFFE;

endpackage

// File: rtl/mem_access_unit.sv
// mem_access_unit: bus initiator driving the memory_block BRAM port for the
// 6502 core. Accepts byte / 16-bit little-endian word requests over a
// valid/ready handshake, issues one or two BRAM byte cycles, absorbs the
// BRAM read latency and returns one rsp_valid pulse per request.
//
// Ports:
//   clk_sys, rst_n (async, active low)
//   req_valid/req_ready, req_write, req_word, req_addr, req_wdata : request
//   rsp_valid, rsp_rdata                                          : response
//   ena, wea, addra, dina, douta                                  : BRAM port
//
// Build option:
//   MEM_PAGE_WRAP_EN - word high byte stays in the same 256-byte page
//                      (NMOS JMP-indirect behaviour); otherwise full increment.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int RD_LATENCY = 1
) (
  input  logic                    clk_sys,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic                    req_word,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic                    rsp_valid,
  output logic [2*DATA_WIDTH-1:0] rsp_rdata,
  output logic                    ena,
  output logic                    wea,
  output logic [ADDR_WIDTH-1:0]   addra,
  output logic [DATA_WIDTH-1:0]   dina,
  input  logic [DATA_WIDTH-1:0]   douta
);

  mau_state_t              state;
  logic                    wr_q;
  logic                    word_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_hi;
  logic [DATA_WIDTH-1:0]   lo_byte;
  logic [ADDR_WIDTH-1:0]   hi_addr;
  logic                    accept;
  cap_tok_t                tok_in;
  cap_tok_t                tok_out;
  cap_tok_t [RD_LATENCY:0] vld_pipe;

  // req_ready is only ever high in IDLE, so accept implies IDLE.
  assign accept  = req_valid & req_ready;
  assign tok_out = vld_pipe[RD_LATENCY];

`ifdef MEM_PAGE_WRAP_EN
  assign hi_addr = {addr_q[ADDR_WIDTH-1:8], addr_q[7:0] + 8'd1};
`else
  assign hi_addr = addr_q + ADDR_WIDTH'(1);
`endif

  // A token enters on the edge that launches a read cycle onto the BRAM
  // port; RD_LATENCY+1 edges later douta carries that byte.
  always_comb begin
    tok_in = '0;
    if (state == IDLE && accept && !req_write) begin
      tok_in.vld  = 1'b1;
      tok_in.last = !req_word;
    end else if (state == LO && word_q && !wr_q) begin
      tok_in.vld  = 1'b1;
      tok_in.hi   = 1'b1;
      tok_in.last = 1'b1;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) vld_pipe <= '0;
    else        vld_pipe <= {vld_pipe[RD_LATENCY-1:0], tok_in};
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      ena       <= 1'b0;
      wea       <= 1'b0;
      addra     <= '0;
      dina      <= '0;
      wr_q      <= 1'b0;
      word_q    <= 1'b0;
      addr_q    <= '0;
      wdata_hi  <= '0;
      lo_byte   <= '0;
    end else begin
      rsp_valid <= 1'b0;

      // Read capture runs off the token pipe, independent of state, since
      // the low byte can arrive while the FSM is still driving HI.
      if (tok_out.vld) begin
        if (!tok_out.hi) lo_byte <= douta;
        if (tok_out.last) begin
          rsp_valid <= 1'b1;
          rsp_rdata <= tok_out.hi ? {douta, lo_byte}
                                  : {{DATA_WIDTH{1'b0}}, douta};
        end
      end

      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (accept) begin
            state     <= LO;
            req_ready <= 1'b0;
            wr_q      <= req_write;
            word_q    <= req_word;
            addr_q    <= req_addr;
            wdata_hi  <= req_wdata[2*DATA_WIDTH-1:DATA_WIDTH];
            ena       <= 1'b1;
            wea       <= req_write;
            addra     <= req_addr;
            dina      <= req_wdata[DATA_WIDTH-1:0];
          end
        end
        LO: begin
          if (word_q) begin
            // ena/wea stay as launched for the second byte
            state <= HI;
            addra <= hi_addr;
            dina  <= wdata_hi;
          end else begin
            ena <= 1'b0;
            wea <= 1'b0;
            if (wr_q) begin
              state     <= IDLE;
              req_ready <= 1'b1;
              rsp_valid <= 1'b1;
            end else begin
              state <= DRAIN;
            end
          end
        end
        HI: begin
          ena <= 1'b0;
          wea <= 1'b0;
          if (wr_q) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b1;
          end else begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (tok_out.vld && tok_out.last) begin
            state     <= IDLE;
            req_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
